// File: rtl/mem_defines.sv
// Shared TCM definitions: response-type encoding, tag width and default TCM size.
package mem_defines;
  localparam int TCM_TAG_W     = 11;
  localparam int TCM_MEM_BYTES = 65536;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RAM_RD     = 3'd1,
    RAM_WR     = 3'd2,
    NOSLOT_OK  = 3'd3,
    NOSLOT_ERR = 3'd4
  } tcm_rsp_e;
endpackage

// File: rtl/tcm_rsp_reg.sv
// Per-port response register: captures what an accepted request owes the core
// and presents it exactly one cycle later.
module tcm_rsp_reg
  import mem_defines::*;
#(
  parameter int TAG_W = TCM_TAG_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_load,
  input  logic [2:0]       i_type,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [31:0]      i_rdata,
  output logic             o_valid,
  output logic             o_error,
  output logic [31:0]      o_data,
  output logic [TAG_W-1:0] o_tag
);
  tcm_rsp_e         r_type;
  logic [TAG_W-1:0] r_tag;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_type <= IDLE;
      r_tag  <= '0;
    end else begin
      r_type <= i_load ? tcm_rsp_e'(i_type) : IDLE;
      r_tag  <= i_load ? i_tag : '0;
    end
  end

  // Gated by reset so a response falling due while reset is held is dropped.
  always_comb begin
    o_valid = rst_i & (r_type != IDLE);
    o_error = rst_i & (r_type == NOSLOT_ERR);
    o_data  = (rst_i && r_type == RAM_RD) ? i_rdata : '0;
    o_tag   = rst_i ? r_tag : '0;
  end
endmodule

// File: rtl/tcm_port_arbiter.sv
// Shares one single-port byte-writable TCM SRAM between instruction fetch and
// data ports; data wins by default, a starvation counter forces fetch through.
module tcm_port_arbiter
  import mem_defines::*;
#(
  parameter  int MEM_BYTES    = TCM_MEM_BYTES,
  parameter  int STARVE_LIMIT = 4,
  localparam int AW           = $clog2(MEM_BYTES) - 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_i_rd_i,
  input  logic [31:0]          mem_i_pc_i,
  input  logic                 mem_i_flush_i,
  input  logic                 mem_i_invalidate_i,
  output logic                 mem_i_accept_o,
  output logic                 mem_i_valid_o,
  output logic                 mem_i_error_o,
  output logic [31:0]          mem_i_inst_o,
  input  logic [31:0]          mem_d_addr_i,
  input  logic [31:0]          mem_d_data_wr_i,
  input  logic                 mem_d_rd_i,
  input  logic [3:0]           mem_d_wr_i,
  input  logic [TCM_TAG_W-1:0] mem_d_req_tag_i,
  input  logic                 mem_d_cacheable_i,
  input  logic                 mem_d_invalidate_i,
  input  logic                 mem_d_writeback_i,
  input  logic                 mem_d_flush_i,
  output logic                 mem_d_accept_o,
  output logic                 mem_d_ack_o,
  output logic                 mem_d_error_o,
  output logic [31:0]          mem_d_data_rd_o,
  output logic [TCM_TAG_W-1:0] mem_d_resp_tag_o,
  output logic                 ram_en_o,
  output logic [3:0]           ram_we_o,
  output logic [AW-1:0]        ram_addr_o,
  output logic [31:0]          ram_wdata_o,
  input  logic [31:0]          ram_rdata_i
);
  localparam logic [31:0] MEM_TOP    = 32'(MEM_BYTES);
  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

  logic       w_d_acc, w_d_maint, w_d_in, w_d_ram, w_d_oor, w_d_win;
  logic       w_i_in, w_i_ram, w_i_oor, w_i_win;
  logic [2:0] w_d_type, w_i_type;
  logic       w_i_tag_unused;
  logic       w_unused_inputs;
  logic [3:0] r_starve_cnt;

  // The TCM is uncached, so fetch-side maintenance and cacheability are ignored.
  assign w_unused_inputs = mem_i_flush_i | mem_i_invalidate_i | mem_d_cacheable_i;

  always_comb begin
    w_d_acc   = mem_d_rd_i | (|mem_d_wr_i);
    w_d_maint = rst_i & ~w_d_acc & (mem_d_flush_i | mem_d_invalidate_i | mem_d_writeback_i);
    w_d_in    = mem_d_addr_i < MEM_TOP;
    w_d_ram   = rst_i & w_d_acc & w_d_in;
    w_d_oor   = rst_i & w_d_acc & ~w_d_in;
    w_i_in    = mem_i_pc_i < MEM_TOP;
    w_i_ram   = rst_i & mem_i_rd_i & w_i_in;
    w_i_oor   = rst_i & mem_i_rd_i & ~w_i_in;

    w_i_win   = w_i_ram & (~w_d_ram | (r_starve_cnt == STARVE_MAX));
    w_d_win   = w_d_ram & ~w_i_win;

    mem_d_accept_o = w_d_maint | w_d_oor | w_d_win;
    mem_i_accept_o = w_i_oor | w_i_win;

    ram_en_o    = w_d_win | w_i_win;
    ram_we_o    = w_d_win ? mem_d_wr_i : 4'b0000;
    ram_wdata_o = w_d_win ? mem_d_data_wr_i : 32'h0;
    ram_addr_o  = '0;
    if (w_i_win)      ram_addr_o = mem_i_pc_i[AW+1:2];
    else if (w_d_win) ram_addr_o = mem_d_addr_i[AW+1:2];

    if (w_d_win)      w_d_type = (|mem_d_wr_i) ? RAM_WR : RAM_RD;
    else if (w_d_oor) w_d_type = NOSLOT_ERR;
    else              w_d_type = NOSLOT_OK;
    w_i_type = w_i_win ? RAM_RD : NOSLOT_ERR;
  end

  // Counts consecutive cycles a fetch that wants the SRAM has been refused.
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      r_starve_cnt <= 4'd0;
    else if (w_i_ram && !w_i_win)
      r_starve_cnt <= (r_starve_cnt == STARVE_MAX) ? STARVE_MAX : r_starve_cnt + 4'd1;
    else
      r_starve_cnt <= 4'd0;
  end

  tcm_rsp_reg #(.TAG_W(TCM_TAG_W)) u_rsp_d (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_load  (mem_d_accept_o),
    .i_type  (w_d_type),
    .i_tag   (mem_d_req_tag_i),
    .i_rdata (ram_rdata_i),
    .o_valid (mem_d_ack_o),
    .o_error (mem_d_error_o),
    .o_data  (mem_d_data_rd_o),
    .o_tag   (mem_d_resp_tag_o)
  );

  tcm_rsp_reg #(.TAG_W(1)) u_rsp_i (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_load  (mem_i_accept_o),
    .i_type  (w_i_type),
    .i_tag   (1'b0),
    .i_rdata (ram_rdata_i),
    .o_valid (mem_i_valid_o),
    .o_error (mem_i_error_o),
    .o_data  (mem_i_inst_o),
    .o_tag   (w_i_tag_unused)
  );
endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Scoreboard bench: a rule-level model predicts grants and responses, a monitor
// pops predicted responses as the DUT produces them.
module tb_tcm_port_arbiter;
  localparam int MEM   = 65536;
  localparam int LIMIT = 4;
  localparam int AW    = 14;

  logic        clk, rst_i;
  logic        mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
  logic [31:0] mem_i_pc_i;
  logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
  logic [31:0] mem_i_inst_o;
  logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
  logic        mem_d_rd_i;
  logic [3:0]  mem_d_wr_i;
  logic [10:0] mem_d_req_tag_i;
  logic        mem_d_cacheable_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
  logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [31:0] mem_d_data_rd_o;
  logic [10:0] mem_d_resp_tag_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [31:0] ram_wdata_o, ram_rdata_i;

  tcm_port_arbiter #(.MEM_BYTES(MEM), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_i_rd_i(mem_i_rd_i), .mem_i_pc_i(mem_i_pc_i), .mem_i_flush_i(mem_i_flush_i),
    .mem_i_invalidate_i(mem_i_invalidate_i), .mem_i_accept_o(mem_i_accept_o),
    .mem_i_valid_o(mem_i_valid_o), .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
    .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i), .mem_d_rd_i(mem_d_rd_i),
    .mem_d_wr_i(mem_d_wr_i), .mem_d_req_tag_i(mem_d_req_tag_i),
    .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_invalidate_i(mem_d_invalidate_i),
    .mem_d_writeback_i(mem_d_writeback_i), .mem_d_flush_i(mem_d_flush_i),
    .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o), .mem_d_error_o(mem_d_error_o),
    .mem_d_data_rd_o(mem_d_data_rd_o), .mem_d_resp_tag_o(mem_d_resp_tag_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  typedef struct { int due; logic err; logic [31:0] data; logic [10:0] tag; } rsp_t;
  rsp_t qd[$];
  rsp_t qi[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  bit [31:0] sram    [0:(1<<AW)-1];
  bit [31:0] ref_mem [0:(1<<AW)-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit [31:0] merge(bit [31:0] old, logic [31:0] d, logic [3:0] be);
    bit [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // External SRAM macro: write-first, read data the cycle after enable.
  initial begin
    sram[14'h040] <= 32'h0000_0013;
    sram[14'h200] <= 32'h1122_3344;
  end
  always @(posedge clk) begin
    if (ram_en_o) begin
      sram[ram_addr_o] <= merge(sram[ram_addr_o], ram_wdata_o, ram_we_o);
      ram_rdata_i      <= merge(sram[ram_addr_o], ram_wdata_o, ram_we_o);
    end
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: grants from the rules, expected responses into queues.
  int   losses;
  logic m_dacc, m_dmaint, m_din, m_iin, m_dram, m_iram, m_islot, m_dslot, m_eacc_d, m_eacc_i;
  rsp_t m_e;
  initial begin
    losses = 0;
    ref_mem[14'h040] = 32'h0000_0013;
    ref_mem[14'h200] = 32'h1122_3344;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        check("rst_comb", 64'({mem_i_accept_o, mem_d_accept_o, ram_en_o, ram_we_o}), 64'(0));
        losses = 0;
      end else begin
        m_dacc   = mem_d_rd_i || (mem_d_wr_i != 4'd0);
        m_dmaint = !m_dacc && (mem_d_flush_i || mem_d_invalidate_i || mem_d_writeback_i);
        m_din    = {32'd0, mem_d_addr_i} < 64'(MEM);
        m_iin    = {32'd0, mem_i_pc_i} < 64'(MEM);
        m_dram   = m_dacc && m_din;
        m_iram   = mem_i_rd_i && m_iin;
        m_islot  = m_iram && (!m_dram || losses >= LIMIT);
        m_dslot  = m_dram && !m_islot;
        m_eacc_d = m_dmaint || (m_dacc && !m_din) || m_dslot;
        m_eacc_i = (mem_i_rd_i && !m_iin) || m_islot;
        check("d_accept", 64'(mem_d_accept_o), 64'(m_eacc_d));
        check("i_accept", 64'(mem_i_accept_o), 64'(m_eacc_i));
        check("ram_en", 64'(ram_en_o), 64'(m_islot || m_dslot));
        if (m_dslot) begin
          check("ram_addr_d", 64'(ram_addr_o), 64'(mem_d_addr_i[15:2]));
          check("ram_we_d", 64'(ram_we_o), 64'(mem_d_wr_i));
          if (mem_d_wr_i != 4'd0) check("ram_wdata", 64'(ram_wdata_o), 64'(mem_d_data_wr_i));
        end
        if (m_islot) begin
          check("ram_addr_i", 64'(ram_addr_o), 64'(mem_i_pc_i[15:2]));
          check("ram_we_i", 64'(ram_we_o), 64'(0));
        end
        losses = (m_iram && !m_islot) ? losses + 1 : 0;
        if (m_eacc_d) begin
          m_e.due  = cyc + 1;
          m_e.err  = m_dacc && !m_din;
          m_e.data = (m_dslot && mem_d_wr_i == 4'd0) ? ref_mem[mem_d_addr_i[15:2]] : 32'd0;
          m_e.tag  = mem_d_req_tag_i;
          qd.push_back(m_e);
          if (m_dslot && mem_d_wr_i != 4'd0)
            ref_mem[mem_d_addr_i[15:2]] = merge(ref_mem[mem_d_addr_i[15:2]], mem_d_data_wr_i, mem_d_wr_i);
        end
        if (m_eacc_i) begin
          m_e.due  = cyc + 1;
          m_e.err  = !m_iin;
          m_e.data = m_islot ? ref_mem[mem_i_pc_i[15:2]] : 32'd0;
          m_e.tag  = 11'd0;
          qi.push_back(m_e);
        end
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the queue heads.
  rsp_t p;
  initial forever begin
    @(negedge clk);
    while (qd.size() > 0 && qd[0].due < cyc) begin check("d_ack_missing", 64'(0), 64'(1)); void'(qd.pop_front()); end
    while (qi.size() > 0 && qi[0].due < cyc) begin check("i_valid_missing", 64'(0), 64'(1)); void'(qi.pop_front()); end
    if (!rst_i) begin
      check("rst_rsp_d", 64'({mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o, mem_d_data_rd_o}), 64'(0));
      check("rst_rsp_i", 64'({mem_i_valid_o, mem_i_error_o, mem_i_inst_o}), 64'(0));
      if (qd.size() > 0 && qd[0].due == cyc) void'(qd.pop_front());
      if (qi.size() > 0 && qi[0].due == cyc) void'(qi.pop_front());
    end else begin
      if (qd.size() > 0 && qd[0].due == cyc) begin
        p = qd.pop_front();
        check("d_ack", 64'(mem_d_ack_o), 64'(1));
        check("d_error", 64'(mem_d_error_o), 64'(p.err));
        check("d_data_rd", 64'(mem_d_data_rd_o), 64'(p.data));
        check("d_resp_tag", 64'(mem_d_resp_tag_o), 64'(p.tag));
      end else if (mem_d_ack_o) check("d_ack_unexpected", 64'(1), 64'(0));
      if (qi.size() > 0 && qi[0].due == cyc) begin
        p = qi.pop_front();
        check("i_valid", 64'(mem_i_valid_o), 64'(1));
        check("i_error", 64'(mem_i_error_o), 64'(p.err));
        check("i_inst", 64'(mem_i_inst_o), 64'(p.data));
      end else if (mem_i_valid_o) check("i_valid_unexpected", 64'(1), 64'(0));
    end
  end

  task automatic step(output logic ai, output logic ad, output logic en);
    @(negedge clk);
    ai = mem_i_accept_o;
    ad = mem_d_accept_o;
    en = ram_en_o;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_d;
    mem_d_addr_i = '0; mem_d_data_wr_i = '0; mem_d_rd_i = 0; mem_d_wr_i = '0;
    mem_d_req_tag_i = '0; mem_d_cacheable_i = 0; mem_d_invalidate_i = 0;
    mem_d_writeback_i = 0; mem_d_flush_i = 0;
  endtask

  task automatic clr_i;
    mem_i_rd_i = 0; mem_i_pc_i = '0; mem_i_flush_i = 0; mem_i_invalidate_i = 0;
  endtask

  function automatic logic [31:0] in_addr();
    int k = $urandom_range(0, 17);
    if (k < 16) return 32'(k * 4);
    if (k == 16) return 32'(MEM - 4);
    return 32'h800;
  endfunction

  function automatic logic [31:0] oor_addr();
    int k = $urandom_range(0, 2);
    if (k == 0) return 32'(MEM);
    if (k == 1) return 32'(MEM + 4 * $urandom_range(1, 1000));
    return 32'hFFFF_FFFC;
  endfunction

  task automatic new_d(output logic pend);
    int r = $urandom_range(0, 9);
    clr_d();
    mem_d_req_tag_i   = 11'($urandom);
    mem_d_cacheable_i = 1'($urandom);
    pend = 1;
    if (r < 2) pend = 0;
    else if (r < 5) begin mem_d_rd_i = 1; mem_d_addr_i = in_addr(); end
    else if (r < 8) begin
      mem_d_wr_i = 4'($urandom_range(1, 15)); mem_d_addr_i = in_addr(); mem_d_data_wr_i = $urandom;
    end else if (r == 8) begin
      case ($urandom_range(0, 2))
        0: mem_d_flush_i = 1;
        1: mem_d_invalidate_i = 1;
        default: mem_d_writeback_i = 1;
      endcase
    end else begin
      mem_d_addr_i = oor_addr();
      if ($urandom_range(0, 1) == 0) mem_d_rd_i = 1;
      else begin mem_d_wr_i = 4'($urandom_range(1, 15)); mem_d_data_wr_i = $urandom; end
    end
    if (!pend) mem_d_cacheable_i = 0;
  endtask

  task automatic new_i(output logic pend);
    int r = $urandom_range(0, 9);
    clr_i();
    pend = (r >= 4);
    if (pend) begin
      mem_i_rd_i = 1;
      mem_i_pc_i = (r == 9) ? 32'(MEM) : in_addr();
      mem_i_flush_i = 1'($urandom);
    end
  endtask

  logic ai, ad, en, dp, ip;
  initial begin
    clr_d(); clr_i();
    rst_i = 0;
    repeat (3) step(ai, ad, en);
    check("reset_accepts", 64'({ai, ad, en}), 64'(0));
    check("reset_rsp", 64'({mem_i_valid_o, mem_d_ack_o, mem_i_error_o, mem_d_error_o, mem_d_resp_tag_o}), 64'(0));
    rst_i = 1;

    mem_i_rd_i = 1; mem_i_pc_i = 32'h100;
    step(ai, ad, en); clr_i();
    check("fetch_accept", 64'(ai), 64'(1));
    check("fetch_valid", 64'(mem_i_valid_o), 64'(1));
    check("fetch_inst", 64'(mem_i_inst_o), 64'h13);

    mem_d_wr_i = 4'b0011; mem_d_addr_i = 32'h800; mem_d_data_wr_i = 32'hAABB_CCDD; mem_d_req_tag_i = 11'h1;
    step(ai, ad, en);
    check("wr_accept", 64'(ad), 64'(1));
    mem_d_wr_i = 4'b0000; mem_d_rd_i = 1; mem_d_req_tag_i = 11'h5;
    step(ai, ad, en); clr_d();
    check("rd_accept", 64'(ad), 64'(1));
    check("wr_rd_data", 64'(mem_d_data_rd_o), 64'h1122_CCDD);
    check("wr_rd_tag", 64'(mem_d_resp_tag_o), 64'h5);

    mem_d_rd_i = 1; mem_d_addr_i = 32'h40; mem_d_req_tag_i = 11'h7;
    mem_i_rd_i = 1; mem_i_pc_i = 32'h0;
    for (int k = 0; k < 10; k++) begin
      step(ai, ad, en);
      check("starve_i_acc", 64'(ai), 64'(k % 5 == 4));
      check("starve_d_acc", 64'(ad), 64'(k % 5 != 4));
    end
    clr_d(); clr_i();

    mem_d_rd_i = 1; mem_d_addr_i = 32'h0001_0000; mem_d_req_tag_i = 11'h3;
    step(ai, ad, en); clr_d();
    check("oor_d_accept", 64'({ad, en}), 64'b10);
    check("oor_d_rsp", 64'({mem_d_ack_o, mem_d_error_o, mem_d_data_rd_o}), {30'd0, 2'b11, 32'd0});
    mem_i_rd_i = 1; mem_i_pc_i = 32'(MEM);
    step(ai, ad, en); clr_i();
    check("oor_i_accept", 64'({ai, en}), 64'b10);
    check("oor_i_rsp", 64'({mem_i_valid_o, mem_i_error_o, mem_i_inst_o}), {30'd0, 2'b11, 32'd0});
    mem_i_rd_i = 1; mem_i_pc_i = 32'(MEM - 4);
    step(ai, ad, en); clr_i();
    check("top_word_i", 64'({ai, en, mem_i_error_o}), 64'b110);

    mem_d_flush_i = 1; mem_i_rd_i = 1; mem_i_pc_i = 32'h100;
    step(ai, ad, en); clr_d(); clr_i();
    check("flush_fetch_acc", 64'({ai, ad, en}), 64'b111);
    check("flush_fetch_rsp", 64'({mem_d_ack_o, mem_d_error_o, mem_i_valid_o, mem_i_inst_o}), {29'd0, 3'b101, 32'h13});

    mem_d_rd_i = 1; mem_d_addr_i = 32'h40; mem_d_req_tag_i = 11'h9;
    mem_i_rd_i = 1; mem_i_pc_i = 32'h0;
    repeat (3) step(ai, ad, en);
    check("pre_rst_d_acc", 64'(ad), 64'(1));
    rst_i = 0;
    #1;
    check("rst_drop_ack", 64'({mem_d_ack_o, mem_d_accept_o, mem_i_accept_o}), 64'(0));
    step(ai, ad, en);
    rst_i = 1;
    for (int k = 0; k < 5; k++) begin
      step(ai, ad, en);
      check("post_rst_i_acc", 64'(ai), 64'(k == 4));
    end
    clr_d(); clr_i();

    dp = 0; ip = 0; ai = 0; ad = 0;
    for (int n = 0; n < 800; n++) begin
      if (!dp || ad) new_d(dp);
      if (!ip || ai) new_i(ip);
      step(ai, ad, en);
    end
    clr_d(); clr_i();
    repeat (3) step(ai, ad, en);
    check("d_queue_drained", 64'(qd.size()), 64'(0));
    check("i_queue_drained", 64'(qi.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tcm_port_arbiter.md
# tcm_port_arbiter

Shares one single-port, byte-writable TCM SRAM between the core's instruction-fetch port (`mem_i_*`) and data port (`mem_d_*`). It sits between `riscv_core` and the SRAM macro and replaces the dual-ported behavioural TCM for synthesis.
- Data requests win by default.
- A starvation counter guarantees forward progress for instruction fetch.
- Range errors and cache-maintenance requests are answered without touching the SRAM.

## Interface
Parameters:
- `MEM_BYTES`, 65536: TCM size in bytes, power of two; word address width `AW = log2(MEM_BYTES)-2`.
- `STARVE_LIMIT`, 4: number of consecutive cycles a pending fetch may lose arbitration before it is forced to win; legal range 1–15.

Ports:
- `clk_i`  in  1: the only clock.
- `rst_i`  in  1: synchronous, active-low reset.
- `mem_i_rd_i` in 1 / `mem_i_pc_i` in 32: fetch request and its byte address (word aligned).
- `mem_i_flush_i`, `mem_i_invalidate_i` in 1: fetch-side maintenance requests.
- `mem_i_accept_o` out 1 / `mem_i_valid_o` out 1 / `mem_i_error_o` out 1 / `mem_i_inst_o` out 32: fetch accept and fetch response.
- `mem_d_addr_i` in 32 / `mem_d_data_wr_i` in 32 / `mem_d_rd_i` in 1 / `mem_d_wr_i` in 4 / `mem_d_req_tag_i` in 11: data request.
- `mem_d_cacheable_i`, `mem_d_invalidate_i`, `mem_d_writeback_i`, `mem_d_flush_i` in 1: data-side request qualifiers and maintenance requests.
- `mem_d_accept_o` out 1 / `mem_d_ack_o` out 1 / `mem_d_error_o` out 1 / `mem_d_data_rd_o` out 32 / `mem_d_resp_tag_o` out 11: data accept and data response.
- `ram_en_o` out 1 / `ram_we_o` out 4 / `ram_addr_o` out AW / `ram_wdata_o` out 32: SRAM request.
- `ram_rdata_i` in 32: SRAM read data, valid the cycle after `ram_en_o`.

## Operation
Request classification:
- A D request is pending when `mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i | mem_d_invalidate_i | mem_d_writeback_i`.
- An I request is pending when `mem_i_rd_i`.
- A "RAM request" is a pending read or write whose address is below `MEM_BYTES`.

Arbitration, evaluated combinationally each cycle:
- Maintenance-only D requests (flush, invalidate or writeback, with no rd and no wr) are always accepted. They use no SRAM slot, so an I request may be granted in the same cycle.
- Out-of-range requests on either port are accepted without an SRAM slot and take an error response.
- When both ports present RAM requests, D wins unless `starve_cnt == STARVE_LIMIT`, in which case I wins.
- When only one port presents a RAM request, it wins.

Accept behaviour:
- `accept_o` asserts in the same cycle as the grant. A port that is not granted sees `accept_o = 0` and must hold its request.
- On a granted RAM request: `ram_en_o = 1`, `ram_addr_o = addr[AW+1:2]`, `ram_we_o = mem_d_wr_i` (0 for reads and for I), `ram_wdata_o = mem_d_data_wr_i`.
- `mem_i_flush_i` and `mem_i_invalidate_i` have no effect; the TCM is not cached.

Starvation counter `starve_cnt` (4 bits):
- Increments when an I RAM request is pending and not granted.
- Clears when I is granted or no I request is pending.
- Saturates at `STARVE_LIMIT`.

Responses are registered and occur exactly 1 cycle after accept:
- Response type per port is tracked in a response register: `IDLE`, `RAM_RD`, `RAM_WR`, `NOSLOT_OK`, `NOSLOT_ERR`.
- `mem_i_valid_o` pulses for one cycle. `mem_i_inst_o = ram_rdata_i` for `RAM_RD`, 0 for error; `mem_i_error_o = 1` for error.
- `mem_d_ack_o` pulses for one cycle and `mem_d_resp_tag_o` returns the accepted tag.
- `mem_d_data_rd_o = ram_rdata_i` for `RAM_RD`, otherwise 0.
- `mem_d_error_o = 1` only for `NOSLOT_ERR`.
- The core never back-pressures responses; there is no response FIFO.

## Timing
Latency:
- Accept in cycle N gives the response in cycle N+1 on both ports.
- Throughput is one RAM access per cycle in total.

Reset (`rst_i = 0` at a rising edge):
- Both response registers go to `IDLE` and `starve_cnt` to 0.
- Registered outputs are 0 from the next cycle: `valid`, `ack`, `error`, `inst`, `data_rd`, `resp_tag`.
- Combinational outputs (`accept_o`, `ram_*`) are forced to 0 while `rst_i = 0`.
- A response that was due in the cycle after reset is dropped.

Boundary conditions:
- An address equal to `MEM_BYTES` is out of range; `MEM_BYTES-4` is in range.
- D read and D write must never be granted simultaneously with an I RAM request.
- Back-to-back D accesses are allowed every cycle, subject to the starvation rule.
- A write followed by a read to the same word in the next cycle returns the new data (SRAM write-first).

## Structure
- The shared package `mem_defines` holds:
  - the response-type enum `tcm_rsp_e`;
  - `TCM_TAG_W = 11`;
  - the default `MEM_BYTES`.
- One sub-module: `tcm_rsp_reg`, instantiated once per port. It holds the response-type register, the captured tag and the error/valid flags.
- Arbitration and the starvation counter live in the top level.

## Test plan
- **Single fetch:** I read at 0x100, RAM word = 0x00000013 → `accept` in cycle N, `mem_i_valid_o = 1` with `inst = 0x00000013` in cycle N+1.
- **Write then read:** D write `wr = 4'b0011`, data 0xAABBCCDD, to word 0x200 (old value 0x11223344), then D read tag 0x5 → `ack` with `data_rd = 0x1122CCDD` and `resp_tag = 0x5`.
- **Starvation:** D and I requests held every cycle, `STARVE_LIMIT = 4` → D granted for 4 cycles, I granted in the 5th, then the pattern repeats.
- **Range errors:** D read at 0x00010000 → accepted, no `ram_en_o`, ack with `error = 1`, `data_rd = 0`. Fetch at `MEM_BYTES` → `valid` with `error = 1`.
- **Flush alongside fetch:** D flush concurrent with an I fetch → both accepted in the same cycle, and both respond in the next cycle.
- **Reset mid-operation:** `rst_i` low in the cycle after a D read accept → no `ack`; all outputs 0; `starve_cnt` reads 0 after release.
